// File: rtl/aes_core.sv
// Byte-serial AES-128 encryptor: 16 load edges, one init edge, ten round edges.
// Optional macro AES_CORE_AUTO_RESTART_EN makes DONE return to LOAD after one cycle.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; zero maps to zero as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] e;
      r = 8'h01;
      e = 8'hFE;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, x);
      end
      return r;
   endfunction

   logic [7:0] inv;

   assign inv = gf_inv(a);
   assign y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_core (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   state,
   input  logic [7:0]   key,
   output logic [127:0] text,
   output logic         done
);
   // Interface: no ready/valid. The source presents one plaintext byte and one key
   // byte on every rising edge while in LOAD; done=1 marks text as a valid ciphertext.
   typedef enum logic [1:0] {LOAD, INIT, ROUND, DONE} fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [3:0]   cnt_q;
   logic [3:0]   round_q;
   logic [127:0] pt_q, key_q, s_q, rk_q, text_q;
   logic         done_q;

   logic [127:0] sb, sr, mc, rnd, nxt_s, nrk;
   logic [31:0]  w3_rot, sub_w, temp_w;
   logic [31:0]  n0, n1, n2, n3;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1B;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   genvar g;

   // Byte order inside the word does not matter for SubBytes, so map lane-for-lane.
   generate
      for (g = 0; g < 16; g++) begin : g_data_sbox
         aes_sbox u_sbox (.a(s_q[8*g +: 8]), .y(sb[8*g +: 8]));
      end
   endgenerate

   // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
   generate
      for (g = 0; g < 16; g++) begin : g_shift_rows
         localparam int R   = g % 4;
         localparam int C   = g / 4;
         localparam int SRC = 4 * ((C + R) % 4) + R;
         assign sr[127-8*g -: 8] = sb[127-8*SRC -: 8];
      end
   endgenerate

   generate
      for (g = 0; g < 4; g++) begin : g_mix_col
         logic [7:0] a0, a1, a2, a3;
         assign a0 = sr[127-32*g -: 8];
         assign a1 = sr[119-32*g -: 8];
         assign a2 = sr[111-32*g -: 8];
         assign a3 = sr[103-32*g -: 8];
         assign mc[127-32*g -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         assign mc[119-32*g -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         assign mc[111-32*g -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         assign mc[103-32*g -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
   endgenerate

   assign w3_rot = {rk_q[23:0], rk_q[31:24]};

   generate
      for (g = 0; g < 4; g++) begin : g_key_sbox
         aes_sbox u_sbox (.a(w3_rot[8*g +: 8]), .y(sub_w[8*g +: 8]));
      end
   endgenerate

   assign temp_w = sub_w ^ {rcon(round_q), 24'h000000};
   assign n0     = rk_q[127:96] ^ temp_w;
   assign n1     = rk_q[95:64]  ^ n0;
   assign n2     = rk_q[63:32]  ^ n1;
   assign n3     = rk_q[31:0]   ^ n2;
   assign nrk    = {n0, n1, n2, n3};

   assign rnd    = (round_q == 4'd10) ? sr : mc;
   assign nxt_s  = rnd ^ nrk;

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         LOAD:    if (cnt_q == 4'd15) fsm_d = INIT;
         INIT:    fsm_d = ROUND;
         ROUND:   if (round_q == 4'd10) fsm_d = DONE;
`ifdef AES_CORE_AUTO_RESTART_EN
         DONE:    fsm_d = LOAD;
`else
         DONE:    fsm_d = DONE;
`endif
         default: fsm_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) fsm_q <= LOAD;
      else        fsm_q <= fsm_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= 4'd0;
         round_q <= 4'd0;
         pt_q    <= '0;
         key_q   <= '0;
         s_q     <= '0;
         rk_q    <= '0;
         text_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         case (fsm_q)
            LOAD: begin
               pt_q  <= {pt_q[119:0], state};
               key_q <= {key_q[119:0], key};
               cnt_q <= cnt_q + 4'd1;
            end
            INIT: begin
               s_q     <= pt_q ^ key_q;
               rk_q    <= key_q;
               round_q <= 4'd1;
            end
            ROUND: begin
               s_q  <= nxt_s;
               rk_q <= nrk;
               if (round_q == 4'd10) begin
                  text_q <= nxt_s;
                  done_q <= 1'b1;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            DONE: begin
`ifdef AES_CORE_AUTO_RESTART_EN
               done_q <= 1'b0;
               cnt_q  <= 4'd0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign text = text_q;
   assign done = done_q;
endmodule

// File: tb/tb_aes_core.sv
// Self-checking bench for aes_core using FIPS-197 vectors and an expected-ciphertext queue.

module tb_aes_core;
   localparam logic [127:0] V1_K = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   localparam logic [127:0] V1_P = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [127:0] V1_C = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] V2_K = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] V2_P = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] V2_C = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
   localparam logic [127:0] V3_C = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   state = 8'h00;
   logic [7:0]   key = 8'h00;
   logic [127:0] text;
   logic         done;

   int n_vec = 0;
   int n_err = 0;
   logic [127:0] exp_q[$];

   aes_core dut (
      .clk   (clk),
      .reset (reset),
      .state (state),
      .key   (key),
      .text  (text),
      .done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves reset released just after an edge, so the next edge is load edge 1.
   task automatic apply_reset();
      reset = 1'b0;
      state = 8'h00;
      key   = 8'h00;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic load_block(input logic [127:0] p, input logic [127:0] k);
      for (int i = 0; i < 16; i++) begin
         state = p[127-8*i -: 8];
         key   = k[127-8*i -: 8];
         tick();
      end
   endtask

   // Starts at edge 17; lat is the edge number at which done was seen, or -1.
   task automatic wait_done(input bit scramble, input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         if (scramble) begin
            state = 8'($urandom_range(0, 255));
            key   = 8'($urandom_range(0, 255));
         end
         tick();
         if (done === 1'b1) begin
            lat = 16 + i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      state = 8'($urandom_range(0, 255));
      key   = 8'($urandom_range(0, 255));
      tick();
      n_vec++;
      if (text !== 128'h0) begin
         n_err++;
         $display("FAIL reset_text: got %h expected %h", text, 128'h0);
      end
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
   endtask

   task automatic test_vector(input logic [127:0] p, input logic [127:0] k,
                              input logic [127:0] c, input bit scramble);
      int lat;
      logic [127:0] want;
      apply_reset();
      exp_q.push_back(c);
      load_block(p, k);
      wait_done(scramble, 40, lat);
      n_vec++;
      if (lat != 27) begin
         n_err++;
         $display("FAIL vector_latency: got %0d expected 27", lat);
      end
      want = exp_q.pop_front();
      n_vec++;
      if (text !== want) begin
         n_err++;
         $display("FAIL vector_text: got %h expected %h", text, want);
      end
   endtask

   task automatic test_zero_block();
      logic [127:0] want;
      apply_reset();
      exp_q.push_back(V3_C);
      state = 8'h00;
      key   = 8'h00;
      for (int e = 1; e <= 27; e++) begin
         tick();
         if (e < 27) begin
            n_vec++;
            if (text !== 128'h0 || done !== 1'b0) begin
               n_err++;
               $display("FAIL zero_early edge %0d: got text=%h done=%b expected 0/0",
                        e, text, done);
            end
         end
      end
      want = exp_q.pop_front();
      n_vec++;
      if (done !== 1'b1 || text !== want) begin
         n_err++;
         $display("FAIL zero_result: got text=%h done=%b expected %h/1", text, done, want);
      end
   endtask

   task automatic test_reset_mid_round();
      int lat;
      logic [127:0] want;
      apply_reset();
      load_block(V1_P, V1_K);
      repeat (5) tick();
      #2;
      reset = 1'b0;
      #1;
      n_vec++;
      if (text !== 128'h0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_now: got text=%h done=%b expected 0/0", text, done);
      end
      repeat (8) tick();
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_hold: got done=%b expected 0", done);
      end
      apply_reset();
      exp_q.push_back(V1_C);
      load_block(V1_P, V1_K);
      wait_done(1'b0, 40, lat);
      want = exp_q.pop_front();
      n_vec++;
      if (lat != 27 || text !== want) begin
         n_err++;
         $display("FAIL midreset_reload: got lat=%0d text=%h expected 27/%h", lat, text, want);
      end
   endtask

   task automatic test_reset_in_done();
      int lat;
      apply_reset();
      load_block(V1_P, V1_K);
      wait_done(1'b0, 40, lat);
      #2;
      reset = 1'b0;
      #1;
      n_vec++;
      if (text !== 128'h0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got text=%h done=%b lat=%0d expected 0/0", text, done, lat);
      end
   endtask

`ifndef AES_CORE_AUTO_RESTART_EN
   task automatic test_terminal();
      int lat;
      logic [127:0] want;
      apply_reset();
      exp_q.push_back(V1_C);
      load_block(V1_P, V1_K);
      wait_done(1'b0, 40, lat);
      want = exp_q.pop_front();
      for (int i = 0; i < 24; i++) begin
         state = 8'($urandom_range(0, 255));
         key   = 8'($urandom_range(0, 255));
         tick();
         n_vec++;
         if (done !== 1'b1 || text !== want) begin
            n_err++;
            $display("FAIL terminal_hold cycle %0d: got text=%h done=%b expected %h/1",
                     i, text, done, want);
         end
      end
   endtask
`else
   task automatic test_back_to_back();
      logic [127:0] first;
      logic [127:0] want;
      apply_reset();
      exp_q.push_back(V1_C);
      exp_q.push_back(V2_C);
      load_block(V1_P, V1_K);
      for (int e = 17; e <= 27; e++) begin
         tick();
         if (e < 27) begin
            n_vec++;
            if (done !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_early1 edge %0d: got done=%b expected 0", e, done);
            end
         end
      end
      first = exp_q.pop_front();
      n_vec++;
      if (done !== 1'b1 || text !== first) begin
         n_err++;
         $display("FAIL b2b_first: got text=%h done=%b expected %h/1", text, done, first);
      end
      state = 8'($urandom_range(0, 255));
      key   = 8'($urandom_range(0, 255));
      tick();
      n_vec++;
      if (done !== 1'b0 || text !== first) begin
         n_err++;
         $display("FAIL b2b_pulse: got text=%h done=%b expected %h/0", text, done, first);
      end
      load_block(V2_P, V2_K);
      for (int e = 45; e <= 55; e++) begin
         tick();
         if (e < 55) begin
            n_vec++;
            if (done !== 1'b0 || text !== first) begin
               n_err++;
               $display("FAIL b2b_hold edge %0d: got text=%h done=%b expected %h/0",
                        e, text, done, first);
            end
         end
      end
      want = exp_q.pop_front();
      n_vec++;
      if (done !== 1'b1 || text !== want) begin
         n_err++;
         $display("FAIL b2b_second: got text=%h done=%b expected %h/1", text, done, want);
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || text !== want) begin
         n_err++;
         $display("FAIL b2b_pulse2: got text=%h done=%b expected %h/0", text, done, want);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_vector(V1_P, V1_K, V1_C, 1'b0);
      test_vector(V2_P, V2_K, V2_C, 1'b0);
      test_zero_block();
      test_vector(V1_P, V1_K, V1_C, 1'b1);
      test_reset_mid_round();
      test_reset_in_done();
`ifndef AES_CORE_AUTO_RESTART_EN
      test_terminal();
`else
      test_back_to_back();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
